// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two memory masters, the arbiter and the shared single-port ram.
// The master modport is the environment side: both requesting masters plus the ram itself.
interface ram_arbiter_if #(
  parameter int unsigned RAM_WIDTH  = 31,
  parameter int unsigned DATA_WIDTH = 32
);
  // Port 0: core load/store path
  logic                  m0_req;
  logic                  m0_we;
  logic                  m0_lock;
  logic [RAM_WIDTH-1:0]  m0_address;
  logic [DATA_WIDTH-1:0] m0_wdata;
  logic                  m0_gnt;
  logic                  m0_rvalid;
  // Port 1: debug / firmware loader
  logic                  m1_req;
  logic                  m1_we;
  logic                  m1_lock;
  logic [RAM_WIDTH-1:0]  m1_address;
  logic [DATA_WIDTH-1:0] m1_wdata;
  logic                  m1_gnt;
  logic                  m1_rvalid;
  // Shared read return
  logic [DATA_WIDTH-1:0] rdata;
  // Ram side
  logic [RAM_WIDTH-1:0]  ram_address;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  modport master (
    output m0_req, m0_we, m0_lock, m0_address, m0_wdata,
    output m1_req, m1_we, m1_lock, m1_address, m1_wdata,
    input  m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, rdata,
    input  ram_address, ram_we, ram_wdata,
    output ram_rdata
  );

  modport slave (
    input  m0_req, m0_we, m0_lock, m0_address, m0_wdata,
    input  m1_req, m1_we, m1_lock, m1_address, m1_wdata,
    output m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, rdata,
    output ram_address, ram_we, ram_wdata,
    input  ram_rdata
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of the single-port data ram.
// One access per cycle, zero-latency grant, bounded locked bursts, registered read return.
module ram_arbiter #(
  parameter int unsigned RAM_WIDTH  = 31,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 4
) (
  input logic           clk,
  input logic           a_reset_n,
  ram_arbiter_if.slave  bus
);

  localparam int unsigned CntW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e                state_q, state_d;
  logic                  last_gnt_q, last_gnt_d;
  logic [CntW-1:0]       burst_cnt_q, burst_cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvalid0_q, rvalid0_d;
  logic                  rvalid1_q, rvalid1_d;

  logic                  gnt0, gnt1;
  logic                  own_cont;
  logic                  sel_lock, sel_we;
  logic [CntW-1:0]       cnt_base;

  // Arbitration: owner first, then round-robin tie-break; all grants gated by reset
  always_comb begin
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    own_cont = 1'b0;
    if (!a_reset_n) begin
      gnt0 = 1'b0;
    end else if (state_q == StOwn0 && bus.m0_req) begin
      gnt0     = 1'b1;
      own_cont = 1'b1;
    end else if (state_q == StOwn1 && bus.m1_req) begin
      gnt1     = 1'b1;
      own_cont = 1'b1;
    end else if (bus.m0_req && bus.m1_req) begin
      // last_gnt_q names the port served last; the other one wins the tie
      if (last_gnt_q) gnt0 = 1'b1;
      else            gnt1 = 1'b1;
    end else if (bus.m0_req) begin
      gnt0 = 1'b1;
    end else if (bus.m1_req) begin
      gnt1 = 1'b1;
    end
  end

  // Ram bus mux: granted port drives the ram, otherwise everything is zero
  always_comb begin
    bus.ram_address = '0;
    bus.ram_wdata   = '0;
    bus.ram_we      = 1'b0;
    sel_lock        = 1'b0;
    sel_we          = 1'b0;
    if (gnt0) begin
      bus.ram_address = bus.m0_address;
      bus.ram_wdata   = bus.m0_wdata;
      bus.ram_we      = bus.m0_we;
      sel_lock        = bus.m0_lock;
      sel_we          = bus.m0_we;
    end else if (gnt1) begin
      bus.ram_address = bus.m1_address;
      bus.ram_wdata   = bus.m1_wdata;
      bus.ram_we      = bus.m1_we;
      sel_lock        = bus.m1_lock;
      sel_we          = bus.m1_we;
    end
  end

  // Next state: ownership, burst count, round-robin pointer and read return
  always_comb begin
    state_d     = StIdle;
    burst_cnt_d = '0;
    last_gnt_d  = last_gnt_q;
    rdata_d     = rdata_q;
    rvalid0_d   = gnt0 && !bus.m0_we;
    rvalid1_d   = gnt1 && !bus.m1_we;
    // A fresh grant (not a continuation of ownership) starts its burst count from zero
    cnt_base    = own_cont ? burst_cnt_q : '0;
    if (gnt0 || gnt1) begin
      last_gnt_d = gnt1;
      if (sel_lock && ((int'(cnt_base) + 1) < int'(MAX_BURST))) begin
        state_d     = gnt1 ? StOwn1 : StOwn0;
        burst_cnt_d = cnt_base + CntW'(1);
      end
      if (!sel_we) rdata_d = bus.ram_rdata;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      state_q     <= StIdle;
      last_gnt_q  <= 1'b1;
      burst_cnt_q <= '0;
      rdata_q     <= '0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      burst_cnt_q <= burst_cnt_d;
      rdata_q     <= rdata_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
    end
  end

  assign bus.m0_gnt    = gnt0;
  assign bus.m1_gnt    = gnt1;
  assign bus.m0_rvalid = rvalid0_q;
  assign bus.m1_rvalid = rvalid1_q;
  assign bus.rdata     = rdata_q;

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the single-port data `ram` between the core load/store path (port 0) and a debug/firmware-loader master (port 1). It sits between the `alu` memory outputs and the `ram` instance. It performs one access per cycle, arbitrates round-robin, supports locked bursts with a bounded length, and returns read data registered, one cycle after grant.

## Interface
- `RAM_WIDTH`, 31: address width of `ram`.
- `DATA_WIDTH`, 32: data word width.
- `MAX_BURST`, 4: maximum consecutive grants a locked master may hold. Must be ≥1.

Ports:
- `clk` in 1: the only clock; all state updates on the rising edge.
- `a_reset_n` in 1: reset, asynchronous, active-low.
- `mN_req` in 1 (N=0,1): access request. Held until `mN_gnt`.
- `mN_we` in 1: 1 = write, 0 = read. Stable while `mN_req` is high.
- `mN_lock` in 1: request to keep ownership after this grant.
- `mN_address` in RAM_WIDTH: word address.
- `mN_wdata` in DATA_WIDTH: write data.
- `mN_gnt` out 1: access performed this cycle (combinational).
- `mN_rvalid` out 1: `rdata` holds this port's read result (registered).
- `rdata` out DATA_WIDTH: shared read-return register.
- `ram_address` out RAM_WIDTH: address to `ram`.
- `ram_we` out 1: write strobe to `ram`.
- `ram_wdata` out DATA_WIDTH: write data to `ram`.
- `ram_rdata` in DATA_WIDTH: asynchronous read data from `ram`.

## Operation
- **State.** `state` ∈ {IDLE, OWN0, OWN1}, `last_gnt` (1 bit), `burst_cnt` ($clog2(MAX_BURST+1) bits).
- **Grant rules.** At most one `mN_gnt` per cycle.
  - IDLE, one requester: grant it.
  - IDLE, both requesting: grant the port ≠ `last_gnt`.
  - OWNn with `mn_req`=1: grant n only. The other port waits.
  - OWNn with `mn_req`=0: ownership is dropped and this cycle arbitrates as IDLE.
- **Bus mux.**
  - Granted port drives `ram_address`, `ram_wdata`; `ram_we` = `mN_we`.
  - No grant: `ram_address`=0, `ram_wdata`=0, `ram_we`=0.
- **Updates on a granted edge:**
  - `last_gnt` ← granted port.
  - If `mN_lock`=1 and `burst_cnt`+1 < MAX_BURST: `state` ← OWNn, `burst_cnt` += 1.
  - Otherwise: `state` ← IDLE, `burst_cnt` ← 0. This is the forced release; `last_gnt` then gives the other port priority.
- **No grant.** `state` ← IDLE, `burst_cnt` ← 0.
- **Read return.**
  - On a granted read: `rdata` ← `ram_rdata` and `mN_rvalid` ← 1 for the granted port.
  - On a write or no grant: both `rvalid` ← 0 and `rdata` holds its value.
- **Ordering.** Write-then-read to the same address on consecutive grants returns the new data, because `ram` commits the write at the edge.

## Timing
- **Reset values** (asynchronous, while `a_reset_n`=0):
  - `state`=IDLE, `last_gnt`=1 (port 0 wins first tie), `burst_cnt`=0, `rdata`=0, `m0_rvalid`=`m1_rvalid`=0.
  - `mN_gnt`=0, `ram_we`=0, `ram_address`=0, `ram_wdata`=0: combinational outputs are gated by reset.
- **Grant latency.** 0 cycles when the bus is free: `gnt` is asserted in the same cycle as `req`.
- **Write.** Commits at the rising edge ending the grant cycle.
- **Read latency.** 1 cycle: `rvalid`/`rdata` are valid the cycle after `gnt` and remain for exactly one cycle.
- **Back-to-back.** One access per cycle, with no bubble between grants or between ports.
- **Boundaries.**
  - **Lock held past MAX_BURST.** The owner gets MAX_BURST consecutive grants. If the other port is requesting, it wins the next cycle; the original owner may re-lock afterwards.
  - **MAX_BURST=1.** Lock has no effect.
  - **Simultaneous requests, owner dropping lock.** The same tie-break via `last_gnt` applies.
  - **Reset mid-burst or mid-read.** Everything returns to reset values immediately. The pending `rvalid` is lost and no `ram_we` pulse reaches `ram` while reset is low.
  - **`mN_req` deasserted without grant.** Legal. No access occurs.

## Test plan
- **Reset.**
  - Stimulus: hold `a_reset_n`=0 with both `req`=1.
  - Required: all `gnt`, `ram_we`, `rvalid` = 0 and `rdata`=0. After release, `m0_gnt`=1 in the first cycle.
- **Single write/read.**
  - Stimulus: port 0 writes 0xDEADBEEF to address 5, then reads address 5.
  - Required: `m0_gnt` in both cycles. `m0_rvalid`=1 with `rdata`=0xDEADBEEF one cycle after the read grant; `m1_rvalid`=0.
- **Round-robin.**
  - Stimulus: both ports request reads continuously, no lock, for 6 cycles.
  - Required: grants alternate 0,1,0,1,0,1, and `rvalid` alternates the same way one cycle later.
- **Locked burst with MAX_BURST=4.**
  - Stimulus: port 1 holds `lock`=1 and `req`=1; port 0 requests throughout.
  - Required: `m1_gnt` for exactly 4 cycles, then `m0_gnt`, then port 1 is again eligible.
- **Owner drop.**
  - Stimulus: port 0 locks, then deasserts `req` in OWN0 while port 1 requests.
  - Required: `m1_gnt`=1 in that same cycle and `state` returns to IDLE.
- **Reset mid-burst.**
  - Stimulus: assert `a_reset_n`=0 during the 2nd cycle of a port 0 locked write burst.
  - Required: `ram_we` drops immediately, the target address keeps its old value, `state`=IDLE, and the first post-reset tie goes to port 0.
